// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter that merges ALU results and register-file read data onto
// the TX FIFO write port, splitting wide ALU results into two bytes (LSB first).
module tx_resp_arbiter #(
  parameter int Data_width = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*Data_width-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    ALU_WIDE,
  input  logic [Data_width-1:0]   Rd_data,
  input  logic                    RdData_valid,
  input  logic                    FIFO_full,
  input  logic                    OVF_CLR,
  output logic [Data_width-1:0]   TX_p_data,
  output logic                    TX_d_valid,
  output logic                    busy,
  output logic                    OVF
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_RF,
    SEND_ALU_LO,
    SEND_ALU_HI
  } state_t;

  state_t                  state_q, state_d;
  logic [2*Data_width-1:0] aluHold_q, aluHold_d;
  logic                    aluWide_q, aluWide_d;
  logic                    aluPend_q, aluPend_d;
  logic [Data_width-1:0]   rfHold_q, rfHold_d;
  logic                    rfPend_q, rfPend_d;
  logic                    lastGrantAlu_q, lastGrantAlu_d;
  logic                    ovf_q, ovf_d;
  logic [Data_width-1:0]   txData_q, txData_d;

  logic writeCommit;
  logic rfDone;
  logic aluDone;
  logic rfAccept;
  logic aluAccept;
  logic rfDrop;
  logic aluDrop;

  // A source's holding register frees in the same cycle its last byte is written,
  // so a back-to-back pulse from that source is accepted rather than dropped.
  assign writeCommit = (state_q != IDLE) && !FIFO_full;
  assign rfDone      = writeCommit && (state_q == SEND_RF);
  assign aluDone     = writeCommit && ((state_q == SEND_ALU_HI) ||
                                       ((state_q == SEND_ALU_LO) && !aluWide_q));
  assign rfAccept    = RdData_valid && (!rfPend_q || rfDone);
  assign aluAccept   = OUT_VALID && (!aluPend_q || aluDone);
  assign rfDrop      = RdData_valid && !rfAccept;
  assign aluDrop     = OUT_VALID && !aluAccept;

  assign TX_d_valid = writeCommit;
  assign TX_p_data  = txData_q;
  assign busy       = (state_q != IDLE) || aluPend_q || rfPend_q;
  assign OVF        = ovf_q;

  always_comb begin
    state_d        = state_q;
    aluHold_d      = aluHold_q;
    aluWide_d      = aluWide_q;
    aluPend_d      = aluPend_q;
    rfHold_d       = rfHold_q;
    rfPend_d       = rfPend_q;
    lastGrantAlu_d = lastGrantAlu_q;
    ovf_d          = ovf_q;
    txData_d       = txData_q;

    if (aluAccept) begin
      aluHold_d = ALU_OUT;
      aluWide_d = ALU_WIDE;
      aluPend_d = 1'b1;
    end else if (aluDone) begin
      aluPend_d = 1'b0;
    end

    if (rfAccept) begin
      rfHold_d = Rd_data;
      rfPend_d = 1'b1;
    end else if (rfDone) begin
      rfPend_d = 1'b0;
    end

    if (aluDrop || rfDrop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end

    // Output data is loaded on entry to each SEND state and zeroed on return to IDLE.
    case (state_q)
      IDLE: begin
        if (rfPend_q && (!aluPend_q || lastGrantAlu_q)) begin
          state_d        = SEND_RF;
          txData_d       = rfHold_q;
          lastGrantAlu_d = 1'b0;
        end else if (aluPend_q) begin
          state_d        = SEND_ALU_LO;
          txData_d       = aluHold_q[Data_width-1:0];
          lastGrantAlu_d = 1'b1;
        end
      end
      SEND_RF: begin
        if (writeCommit) begin
          state_d  = IDLE;
          txData_d = '0;
        end
      end
      SEND_ALU_LO: begin
        if (writeCommit) begin
          if (aluWide_q) begin
            state_d  = SEND_ALU_HI;
            txData_d = aluHold_q[2*Data_width-1:Data_width];
          end else begin
            state_d  = IDLE;
            txData_d = '0;
          end
        end
      end
      SEND_ALU_HI: begin
        if (writeCommit) begin
          state_d  = IDLE;
          txData_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        txData_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      aluHold_q      <= '0;
      aluWide_q      <= 1'b0;
      aluPend_q      <= 1'b0;
      rfHold_q       <= '0;
      rfPend_q       <= 1'b0;
      lastGrantAlu_q <= 1'b1;
      ovf_q          <= 1'b0;
      txData_q       <= '0;
    end else begin
      state_q        <= state_d;
      aluHold_q      <= aluHold_d;
      aluWide_q      <= aluWide_d;
      aluPend_q      <= aluPend_d;
      rfHold_q       <= rfHold_d;
      rfPend_q       <= rfPend_d;
      lastGrantAlu_q <= lastGrantAlu_d;
      ovf_q          <= ovf_d;
      txData_q       <= txData_d;
    end
  end

  // A SEND state is only ever reached with its source's hold still pending.
  assert property (@(posedge CLK) disable iff (!RST)
    (state_q == IDLE) |-> (txData_q == '0));
  assert property (@(posedge CLK) disable iff (!RST)
    (state_q == SEND_RF) |-> rfPend_q);
  assert property (@(posedge CLK) disable iff (!RST)
    ((state_q == SEND_ALU_LO) || (state_q == SEND_ALU_HI)) |-> aluPend_q);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter: stimulus pushes expected FIFO writes
// (byte and cycle) into a queue that a negedge monitor pops and checks.
module tb_tx_resp_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic        ALU_WIDE = 1'b0;
  logic [7:0]  Rd_data = '0;
  logic        RdData_valid = 1'b0;
  logic        FIFO_full = 1'b0;
  logic        OVF_CLR = 1'b0;
  logic [7:0]  TX_p_data;
  logic        TX_d_valid;
  logic        busy;
  logic        OVF;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   k;

  tx_resp_arbiter #(.Data_width(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ALU_OUT      (ALU_OUT),
    .OUT_VALID    (OUT_VALID),
    .ALU_WIDE     (ALU_WIDE),
    .Rd_data      (Rd_data),
    .RdData_valid (RdData_valid),
    .FIFO_full    (FIFO_full),
    .OVF_CLR      (OVF_CLR),
    .TX_p_data    (TX_p_data),
    .TX_d_valid   (TX_d_valid),
    .busy         (busy),
    .OVF          (OVF)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Every FIFO write is matched against the oldest expected byte and its cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (TX_d_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write cycle %0d: got data 0x%02h, expected no write", cyc, TX_p_data);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (TX_p_data !== e.data) begin
          errors++;
          $display("[TB] FAIL write_data cycle %0d: got 0x%02h, expected 0x%02h", cyc, TX_p_data, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL write_cycle data 0x%02h: got cycle %0d, expected cycle %0d", e.data, cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectWrite(input logic [7:0] data, input int when);
    exp_t e;
    e.data = data;
    e.cyc  = when;
    expQ.push_back(e);
  endtask

  // Drives one-cycle source pulses in the current cycle and returns one cycle later.
  task automatic applyStimulus(input logic rfV, input logic [7:0] rfD,
                               input logic aluV, input logic [15:0] aluD,
                               input logic wide);
    RdData_valid = rfV;
    Rd_data      = rfD;
    OUT_VALID    = aluV;
    ALU_OUT      = aluD;
    ALU_WIDE     = wide;
    step();
    RdData_valid = 1'b0;
    OUT_VALID    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%02h, expected 0x%02h", name, cyc, act, exp);
    end
  endtask

  task automatic applyReset();
    RST = 1'b0;
    step();
    step();
    checkOutput("reset_valid", {7'd0, TX_d_valid}, 8'd0);
    checkOutput("reset_data", TX_p_data, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'd0);
    checkOutput("reset_ovf", {7'd0, OVF}, 8'd0);
    RST = 1'b1;
    step();
  endtask

  initial begin
    $display("[TB] tx_resp_arbiter directed test start");
    applyReset();
    step();

    // Single RF read: write exactly two cycles after the pulse, then idle.
    n = cyc;
    expectWrite(8'hA5, n + 2);
    applyStimulus(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0);
    @(negedge CLK);
    checkOutput("rf_busy_pending", {7'd0, busy}, 8'd1);
    step();
    step();
    @(negedge CLK);
    checkOutput("rf_busy_done", {7'd0, busy}, 8'd0);
    checkOutput("idle_data_zero", TX_p_data, 8'h00);
    repeat (2) step();

    // Wide ALU result goes out LSB then MSB; narrow sends the low byte only.
    n = cyc;
    expectWrite(8'h34, n + 2);
    expectWrite(8'h12, n + 3);
    applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234, 1'b1);
    repeat (5) step();
    n = cyc;
    expectWrite(8'h34, n + 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
    repeat (3) step();
    @(negedge CLK);
    checkOutput("narrow_busy_done", {7'd0, busy}, 8'd0);
    step();

    // Tie right after reset goes to RF; after a lone RF grant a tie goes to ALU.
    applyReset();
    n = cyc;
    expectWrite(8'h5A, n + 2);
    expectWrite(8'hEF, n + 4);
    expectWrite(8'hBE, n + 5);
    applyStimulus(1'b1, 8'h5A, 1'b1, 16'hBEEF, 1'b1);
    repeat (6) step();
    n = cyc;
    expectWrite(8'h77, n + 2);
    applyStimulus(1'b1, 8'h77, 1'b0, 16'h0000, 1'b0);
    repeat (3) step();
    n = cyc;
    expectWrite(8'h76, n + 2);
    expectWrite(8'h98, n + 3);
    expectWrite(8'hC3, n + 5);
    applyStimulus(1'b1, 8'hC3, 1'b1, 16'h9876, 1'b1);
    repeat (6) step();

    // Backpressure in SEND_ALU_HI: hold the MSB until full drops.
    n = cyc;
    expectWrite(8'h34, n + 2);
    expectWrite(8'h12, n + 8);
    applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234, 1'b1);
    step();
    step();
    FIFO_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("bp_valid_low", {7'd0, TX_d_valid}, 8'd0);
      checkOutput("bp_data_held", TX_p_data, 8'h12);
      step();
    end
    FIFO_full = 1'b0;
    repeat (3) step();

    // Overflow: second RF pulse is dropped; set beats a simultaneous clear.
    FIFO_full = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b0, 16'h0000, 1'b0);
    OVF_CLR = 1'b1;
    applyStimulus(1'b1, 8'h22, 1'b0, 16'h0000, 1'b0);
    OVF_CLR = 1'b0;
    @(negedge CLK);
    checkOutput("ovf_set", {7'd0, OVF}, 8'd1);
    step();
    @(negedge CLK);
    checkOutput("ovf_stall_data", TX_p_data, 8'h11);
    step();
    FIFO_full = 1'b0;
    k = cyc;
    expectWrite(8'h11, k);
    step();
    @(negedge CLK);
    checkOutput("ovf_sticky", {7'd0, OVF}, 8'd1);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    @(negedge CLK);
    checkOutput("ovf_cleared", {7'd0, OVF}, 8'd0);
    step();

    // A pulse in the cycle of the final RF write is accepted without overflow.
    n = cyc;
    expectWrite(8'h33, n + 2);
    expectWrite(8'h44, n + 4);
    applyStimulus(1'b1, 8'h33, 1'b0, 16'h0000, 1'b0);
    step();
    applyStimulus(1'b1, 8'h44, 1'b0, 16'h0000, 1'b0);
    @(negedge CLK);
    checkOutput("final_write_no_ovf", {7'd0, OVF}, 8'd0);
    repeat (4) step();

    // Reset one cycle after the LSB write: the MSB must never appear.
    n = cyc;
    expectWrite(8'h34, n + 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234, 1'b1);
    step();
    step();
    RST = 1'b0;
    #1;
    checkOutput("midreset_valid", {7'd0, TX_d_valid}, 8'd0);
    checkOutput("midreset_data", TX_p_data, 8'h00);
    checkOutput("midreset_busy", {7'd0, busy}, 8'd0);
    step();
    step();
    RST = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    checkOutput("after_reset_busy", {7'd0, busy}, 8'd0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
    checkOutput("pending_writes", expQ.size() > 255 ? 8'hFF : 8'(expQ.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
